// File: rtl/spu_mul_seq_pkg.sv
// spu_mul_seq_pkg
// Shared definitions for the SPU product-scanning multiply sequencer:
// default counter width and the sequencer state encoding.
package spu_mul_seq_pkg;

    // Default width of the word count and the i/j index counters (N <= 15).
    localparam int SEQ_LEN_W = 4;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARST = 3'd1,
        ST_MAC  = 3'd2,
        ST_SHF  = 3'd3,
        ST_DONE = 3'd4
    } seq_state_e;

endpackage

// File: rtl/spu_mul_seq_if.sv
// spu_mul_seq_if
// Bundles the SPU-side control (start/len/sq/abort, busy/done, operand
// indices) and the multiplier-control handshake (MAC request, ACCUM reset
// and shift requests, ack/shift-ack).
//   slave  : the sequencer (spu_mul_seq)
//   master : the SPU engine plus the multiplier control
interface spu_mul_seq_if #(
    parameter int LEN_W = spu_mul_seq_pkg::SEQ_LEN_W
) ();
    logic             spu_seq_start;
    logic [LEN_W-1:0] spu_seq_len;
    logic             spu_seq_sq;
    logic             spu_seq_abort;
    logic             spu_seq_busy;
    logic             spu_seq_done;
    logic [LEN_W-1:0] spu_seq_aidx;
    logic [LEN_W-1:0] spu_seq_bidx;
    logic             spu_mul_req_vld;
    logic             spu_mul_acc;
    logic             spu_mul_mulres_lshft;
    logic             spu_mul_areg_rst;
    logic             spu_mul_areg_shf;
    logic             mul_spu_ack;
    logic             mul_spu_shf_ack;

    modport slave (
        input  spu_seq_start, spu_seq_len, spu_seq_sq, spu_seq_abort,
        input  mul_spu_ack, mul_spu_shf_ack,
        output spu_seq_busy, spu_seq_done, spu_seq_aidx, spu_seq_bidx,
        output spu_mul_req_vld, spu_mul_acc, spu_mul_mulres_lshft,
        output spu_mul_areg_rst, spu_mul_areg_shf
    );

    modport master (
        output spu_seq_start, spu_seq_len, spu_seq_sq, spu_seq_abort,
        output mul_spu_ack, mul_spu_shf_ack,
        input  spu_seq_busy, spu_seq_done, spu_seq_aidx, spu_seq_bidx,
        input  spu_mul_req_vld, spu_mul_acc, spu_mul_mulres_lshft,
        input  spu_mul_areg_rst, spu_mul_areg_shf
    );
endinterface

// File: rtl/spu_mul_seq_ctr.sv
// spu_mul_seq_ctr
// Row (i) / column (j) counter pair for product scanning.
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : clear i and j (start / abort)
//   row_inc_i    : advance to the next row of the current column
//   col_inc_i    : advance to the next column, row back to 0
//   sq_i, n_i    : latched square mode and word count
//   i_o, j_o     : current row and column
//   last_row_o   : i has reached imax(j) (j, or j/2 in square mode)
//   last_col_o   : j is the final column N-1
module spu_mul_seq_ctr
    import spu_mul_seq_pkg::*;
#(
    parameter int LEN_W = SEQ_LEN_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             row_inc_i,
    input  logic             col_inc_i,
    input  logic             sq_i,
    input  logic [LEN_W-1:0] n_i,
    output logic [LEN_W-1:0] i_o,
    output logic [LEN_W-1:0] j_o,
    output logic             last_row_o,
    output logic             last_col_o
);
    localparam logic [LEN_W-1:0] ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] ZERO = {LEN_W{1'b0}};

    logic [LEN_W-1:0] i_q, i_d;
    logic [LEN_W-1:0] j_q, j_d;
    logic [LEN_W-1:0] imax_s;

    // Squaring only visits i <= j-i, i.e. the lower half of each column.
    assign imax_s     = sq_i ? {1'b0, j_q[LEN_W-1:1]} : j_q;
    assign last_row_o = (i_q == imax_s);
    assign last_col_o = (j_q == (n_i - ONE));
    assign i_o        = i_q;
    assign j_o        = j_q;

    // Next-state for the counters; clear has priority over any advance.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (clr_i) begin
            i_d = ZERO;
            j_d = ZERO;
        end else if (col_inc_i) begin
            i_d = ZERO;
            j_d = j_q + ONE;
        end else if (row_inc_i) begin
            i_d = i_q + ONE;
        end else begin
            i_d = i_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            i_q <= ZERO;
            j_q <= ZERO;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end
endmodule

// File: rtl/spu_mul_seq.sv
// spu_mul_seq
// Product-scanning sequencer between the SPU modular-arithmetic engine and
// the shared multiplier control. Per run: one ACCUM reset, then for each
// column j the MACs A[i]*B[j-i] (i = 0..imax(j)), then one ACCUM >>64 shift.
//   rclk, rst : clock, async active-high reset
//   bus       : spu_mul_seq_if slave modport (SPU control + multiplier handshake)
// Every output is a decode of the state, counter and latched-mode flops.
module spu_mul_seq
    import spu_mul_seq_pkg::*;
#(
    parameter int LEN_W = SEQ_LEN_W
) (
    input  logic           rclk,
    input  logic           rst,
    spu_mul_seq_if.slave   bus
);
    localparam logic [LEN_W-1:0] ZERO = {LEN_W{1'b0}};

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] n_q, n_d;
    logic             sq_q, sq_d;

    logic [LEN_W-1:0] i_s, j_s, bidx_s;
    logic             last_row_s, last_col_s;
    logic             start_ok_s, clr_s, row_inc_s, col_inc_s;
    logic             in_mac_s;

    // A start is only honoured from IDLE, and abort overrides it.
    assign start_ok_s = bus.spu_seq_start & (state_q == ST_IDLE) & ~bus.spu_seq_abort;
    assign clr_s      = start_ok_s | bus.spu_seq_abort;
    assign row_inc_s  = (state_q == ST_MAC) & bus.mul_spu_ack & ~last_row_s & ~bus.spu_seq_abort;
    assign col_inc_s  = (state_q == ST_SHF) & bus.mul_spu_shf_ack & ~last_col_s & ~bus.spu_seq_abort;

    spu_mul_seq_ctr #(.LEN_W(LEN_W)) u_ctr (
        .clk_i      (rclk),
        .rst_i      (rst),
        .clr_i      (clr_s),
        .row_inc_i  (row_inc_s),
        .col_inc_i  (col_inc_s),
        .sq_i       (sq_q),
        .n_i        (n_q),
        .i_o        (i_s),
        .j_o        (j_s),
        .last_row_o (last_row_s),
        .last_col_o (last_col_s)
    );

    // Next-state logic and latching of N / square mode on an accepted start.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        sq_d    = sq_q;
        if (start_ok_s) begin
            n_d  = bus.spu_seq_len;
            sq_d = bus.spu_seq_sq;
        end else begin
            n_d  = n_q;
            sq_d = sq_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d = (bus.spu_seq_len != ZERO) ? ST_ARST : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARST: state_d = ST_MAC;
            ST_MAC: begin
                if (bus.mul_spu_ack) begin
                    state_d = last_row_s ? ST_SHF : ST_MAC;
                end else begin
                    state_d = ST_MAC;
                end
            end
            ST_SHF: begin
                if (bus.mul_spu_shf_ack) begin
                    state_d = last_col_s ? ST_DONE : ST_MAC;
                end else begin
                    state_d = ST_SHF;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.spu_seq_abort) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // State and latched-operand registers.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= ZERO;
            sq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            sq_q    <= sq_d;
        end
    end

    assign in_mac_s = (state_q == ST_MAC);
    assign bidx_s   = j_s - i_s;

    // Indices are forced to zero outside MAC so idle outputs are all-zero.
    assign bus.spu_seq_busy         = (state_q != ST_IDLE);
    assign bus.spu_seq_done         = (state_q == ST_DONE);
    assign bus.spu_seq_aidx         = in_mac_s ? i_s : ZERO;
    assign bus.spu_seq_bidx         = in_mac_s ? bidx_s : ZERO;
    assign bus.spu_mul_req_vld      = in_mac_s;
    assign bus.spu_mul_acc          = in_mac_s;
    // Off-diagonal square terms appear twice in A*A, so double them once.
    assign bus.spu_mul_mulres_lshft = in_mac_s & sq_q & (i_s != bidx_s);
    assign bus.spu_mul_areg_rst     = (state_q == ST_ARST);
    assign bus.spu_mul_areg_shf     = (state_q == ST_SHF);
endmodule

// File: tb/tb_spu_mul_seq.sv
module tb_spu_mul_seq;
    localparam int LW = 4;
    localparam logic [3:0] EV_ARST = 4'd1;
    localparam logic [3:0] EV_MAC  = 4'd2;
    localparam logic [3:0] EV_SHF  = 4'd3;
    localparam logic [3:0] EV_DONE = 4'd4;

    logic rclk = 1'b0;
    logic rst;
    always #5 rclk = ~rclk;

    spu_mul_seq_if #(.LEN_W(LW)) bus ();
    spu_mul_seq #(.LEN_W(LW)) dut (.rclk(rclk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [15:0] sb[$];

    // Responder configuration.
    int   shf_delay  = 0;
    int   shf_limit  = 1000000;
    int   shf_cnt    = 0;
    int   stall_left = 0;
    logic [3:0] stall_a = 4'd0;
    logic [3:0] stall_b = 4'd0;
    logic junk = 1'b0;
    int   mac_acc  = 0;
    int   shf_done = 0;

    function automatic logic [15:0] mk(logic [3:0] k, logic [3:0] a, logic [3:0] b, logic l);
        return {k, a, b, l, 3'b000};
    endfunction

    // Reference product-scanning order.
    task automatic push_run(int n, bit sq);
        if (n == 0) begin
            sb.push_back(mk(EV_DONE, 4'd0, 4'd0, 1'b0));
        end else begin
            sb.push_back(mk(EV_ARST, 4'd0, 4'd0, 1'b0));
            for (int j = 0; j < n; j++) begin
                int imax;
                imax = sq ? (j / 2) : j;
                for (int i = 0; i <= imax; i++)
                    sb.push_back(mk(EV_MAC, 4'(i), 4'(j - i), sq && (i != j - i)));
                sb.push_back(mk(EV_SHF, 4'd0, 4'd0, 1'b0));
            end
            sb.push_back(mk(EV_DONE, 4'd0, 4'd0, 1'b0));
        end
    endtask

    // Multiplier-control responder plus scoreboard monitor.
    always @(negedge rclk) begin
        logic [15:0] obs, exp_ev;
        bit v;
        if (bus.spu_mul_req_vld) begin
            if (stall_left > 0 && bus.spu_seq_aidx == stall_a && bus.spu_seq_bidx == stall_b) begin
                bus.mul_spu_ack = 1'b0;
                stall_left--;
            end else begin
                bus.mul_spu_ack = 1'b1;
            end
        end else begin
            bus.mul_spu_ack = junk;
        end
        if (bus.spu_mul_areg_shf) begin
            bus.mul_spu_shf_ack = (shf_cnt >= shf_delay) && (shf_done < shf_limit);
            shf_cnt++;
        end else begin
            shf_cnt = 0;
            bus.mul_spu_shf_ack = junk;
        end
        if (!rst) begin
            v = 1'b0;
            obs = 16'd0;
            if (bus.spu_mul_areg_rst) begin
                obs = mk(EV_ARST, 4'd0, 4'd0, 1'b0); v = 1'b1;
            end else if (bus.spu_mul_req_vld && bus.mul_spu_ack) begin
                obs = mk(EV_MAC, bus.spu_seq_aidx, bus.spu_seq_bidx, bus.spu_mul_mulres_lshft);
                v = 1'b1; mac_acc++;
            end else if (bus.spu_mul_areg_shf && bus.mul_spu_shf_ack) begin
                obs = mk(EV_SHF, 4'd0, 4'd0, 1'b0); v = 1'b1; shf_done++;
            end else if (bus.spu_seq_done) begin
                obs = mk(EV_DONE, 4'd0, 4'd0, 1'b0); v = 1'b1;
            end
            if (v) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected got=%h want=none t=%0t", obs, $time);
                end else begin
                    exp_ev = sb.pop_front();
                    if (obs !== exp_ev) begin
                        bad++;
                        $display("FAIL sb_event got=%h want=%h t=%0t", obs, exp_ev, $time);
                    end
                end
            end
            total++;
            if (bus.spu_mul_acc !== bus.spu_mul_req_vld) begin
                bad++;
                $display("FAIL acc_flag got=%b want=%b", bus.spu_mul_acc, bus.spu_mul_req_vld);
            end
        end
    end

    task automatic start_run(int n, bit sq);
        bus.spu_seq_start = 1'b1;
        bus.spu_seq_len   = 4'(n);
        bus.spu_seq_sq    = sq;
        @(negedge rclk);
        bus.spu_seq_start = 1'b0;
    endtask

    task automatic wait_done(string name);
        int k;
        for (k = 0; k < 2000; k++) begin
            if (bus.spu_seq_done === 1'b1) break;
            @(negedge rclk);
        end
        total++;
        if (k >= 2000) begin
            bad++;
            $display("FAIL %s_timeout got=no_done want=done", name);
        end
        @(negedge rclk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_sb_left got=%0d want=0", name, sb.size());
        end
    endtask

    task automatic check_idle_outputs(string name);
        logic [15:0] got;
        got = {bus.spu_seq_busy, bus.spu_seq_done, bus.spu_mul_req_vld, bus.spu_mul_acc,
               bus.spu_mul_mulres_lshft, bus.spu_mul_areg_rst, bus.spu_mul_areg_shf,
               bus.spu_seq_aidx, bus.spu_seq_bidx, 1'b0};
        total++;
        if (got !== 16'd0) begin
            bad++;
            $display("FAIL %s_outputs got=%h want=0000", name, got);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.spu_seq_start = 1'b0; bus.spu_seq_len = 4'd0;
        bus.spu_seq_sq = 1'b0;    bus.spu_seq_abort = 1'b0;
        repeat (3) @(negedge rclk);
        check_idle_outputs("reset_held");
        rst = 1'b0;
        @(negedge rclk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_n1_timing();
        logic [3:0] got, want;
        shf_delay = 2;
        push_run(1, 1'b0);
        bus.spu_seq_start = 1'b1; bus.spu_seq_len = 4'd1; bus.spu_seq_sq = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge rclk);
            if (c == 1) bus.spu_seq_start = 1'b0;
            got  = {bus.spu_mul_areg_rst, bus.spu_mul_req_vld, bus.spu_mul_areg_shf, bus.spu_seq_done};
            want = {c == 1, c == 2, (c >= 3 && c <= 5), c == 6};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL n1_cycle%0d got=%b want=%b", c, got, want);
            end
        end
        @(negedge rclk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL n1_sb_left got=%0d want=0", sb.size());
        end
        shf_delay = 0;
    endtask

    task automatic test_normal3();
        int m0, s0;
        m0 = mac_acc; s0 = shf_done;
        push_run(3, 1'b0);
        start_run(3, 1'b0);
        wait_done("normal3");
        total++;
        if (mac_acc - m0 != 6) begin bad++; $display("FAIL normal3_macs got=%0d want=6", mac_acc - m0); end
        total++;
        if (shf_done - s0 != 3) begin bad++; $display("FAIL normal3_shifts got=%0d want=3", shf_done - s0); end
    endtask

    task automatic test_square3();
        int m0, s0;
        m0 = mac_acc; s0 = shf_done;
        push_run(3, 1'b1);
        start_run(3, 1'b1);
        wait_done("square3");
        total++;
        if (mac_acc - m0 != 4) begin bad++; $display("FAIL square3_macs got=%0d want=4", mac_acc - m0); end
        total++;
        if (shf_done - s0 != 3) begin bad++; $display("FAIL square3_shifts got=%0d want=3", shf_done - s0); end
    endtask

    task automatic test_stall();
        int k;
        stall_a = 4'd0; stall_b = 4'd1; stall_left = 5;
        push_run(3, 1'b0);
        start_run(3, 1'b0);
        for (k = 0; k < 100; k++) begin
            if (bus.spu_mul_req_vld && bus.spu_seq_aidx == 4'd0 && bus.spu_seq_bidx == 4'd1) break;
            @(negedge rclk);
        end
        total++;
        if (k >= 100) begin bad++; $display("FAIL stall_find got=none want=mac(0,1)"); end
        for (int c = 0; c < 6; c++) begin
            total++;
            if ({bus.spu_mul_req_vld, bus.spu_seq_aidx, bus.spu_seq_bidx} !== {1'b1, 4'd0, 4'd1}) begin
                bad++;
                $display("FAIL stall_hold%0d got=%b/%0d/%0d want=1/0/1", c,
                         bus.spu_mul_req_vld, bus.spu_seq_aidx, bus.spu_seq_bidx);
            end
            @(negedge rclk);
        end
        total++;
        if ({bus.spu_mul_req_vld, bus.spu_seq_aidx, bus.spu_seq_bidx} !== {1'b1, 4'd1, 4'd0}) begin
            bad++;
            $display("FAIL stall_advance got=%b/%0d/%0d want=1/1/0",
                     bus.spu_mul_req_vld, bus.spu_seq_aidx, bus.spu_seq_bidx);
        end
        wait_done("stall");
        stall_left = 0;
    endtask

    task automatic test_busy_start();
        junk = 1'b1;
        push_run(4, 1'b1);
        start_run(4, 1'b1);
        repeat (3) @(negedge rclk);
        total++;
        if (bus.spu_seq_busy !== 1'b1) begin bad++; $display("FAIL busy_flag got=%b want=1", bus.spu_seq_busy); end
        bus.spu_seq_start = 1'b1; bus.spu_seq_len = 4'd2; bus.spu_seq_sq = 1'b0;
        @(negedge rclk);
        bus.spu_seq_start = 1'b0;
        wait_done("busy_start");
        junk = 1'b0;
    endtask

    task automatic test_abort();
        int k;
        // abort beats a simultaneous start
        bus.spu_seq_start = 1'b1; bus.spu_seq_abort = 1'b1; bus.spu_seq_len = 4'd2;
        @(negedge rclk);
        bus.spu_seq_start = 1'b0; bus.spu_seq_abort = 1'b0;
        check_idle_outputs("abort_vs_start");
        shf_limit = shf_done + 1;
        sb.push_back(mk(EV_ARST, 4'd0, 4'd0, 1'b0));
        sb.push_back(mk(EV_MAC, 4'd0, 4'd0, 1'b0));
        sb.push_back(mk(EV_SHF, 4'd0, 4'd0, 1'b0));
        sb.push_back(mk(EV_MAC, 4'd0, 4'd1, 1'b0));
        sb.push_back(mk(EV_MAC, 4'd1, 4'd0, 1'b0));
        start_run(4, 1'b0);
        for (k = 0; k < 100; k++) begin
            if (bus.spu_mul_areg_shf && shf_done == shf_limit) break;
            @(negedge rclk);
        end
        total++;
        if (k >= 100) begin bad++; $display("FAIL abort_find got=none want=shf_col1"); end
        @(negedge rclk);
        bus.spu_seq_abort = 1'b1;
        @(negedge rclk);
        bus.spu_seq_abort = 1'b0;
        check_idle_outputs("abort_next");
        for (int c = 0; c < 5; c++) begin
            @(negedge rclk);
            total++;
            if (bus.spu_seq_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=1 want=0"); end
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL abort_sb_left got=%0d want=0", sb.size()); end
        shf_limit = 1000000;
        push_run(4, 1'b0);
        start_run(4, 1'b0);
        total++;
        if (bus.spu_mul_areg_rst !== 1'b1) begin
            bad++; $display("FAIL abort_restart_arst got=%b want=1", bus.spu_mul_areg_rst);
        end
        wait_done("abort_restart");
    endtask

    task automatic test_reset_mid();
        int k;
        push_run(3, 1'b0);
        start_run(3, 1'b0);
        for (k = 0; k < 100; k++) begin
            if (bus.spu_mul_req_vld) break;
            @(negedge rclk);
        end
        total++;
        if (k >= 100) begin bad++; $display("FAIL rstmid_find got=none want=mac"); end
        #2 rst = 1'b1;
        #1 check_idle_outputs("rstmid_async");
        sb.delete();
        @(negedge rclk);
        rst = 1'b0;
        @(negedge rclk);
        push_run(0, 1'b0);
        start_run(0, 1'b0);
        total++;
        if ({bus.spu_seq_done, bus.spu_mul_req_vld, bus.spu_mul_areg_rst} !== 3'b100) begin
            bad++;
            $display("FAIL n0_done_cycle1 got=%b want=100",
                     {bus.spu_seq_done, bus.spu_mul_req_vld, bus.spu_mul_areg_rst});
        end
        @(negedge rclk);
        check_idle_outputs("n0_after");
        @(negedge rclk);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL n0_sb_left got=%0d want=0", sb.size()); end
    endtask

    initial begin
        bus.mul_spu_ack = 1'b0;
        bus.mul_spu_shf_ack = 1'b0;
        test_reset();
        test_n1_timing();
        test_normal3();
        test_square3();
        test_stall();
        test_busy_start();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
